// File: rtl/nasti_lite_uart_arb_pkg.sv
// Shared types for the NASTI-Lite UART arbiter: FSM state encoding and the
// UART data register offset used as the default bus address.
package nasti_lite_uart_arb_pkg;

  localparam int UART_DATA_REG = 0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD      = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } state_t;

endpackage

// File: rtl/nasti_lite_uart_arbiter_rr_arbiter.sv
// Rotating-priority arbiter: search starts at ptr and wraps; a ptr tied to 0
// degenerates to fixed priority with the lowest index winning.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    int c;
    logic [IDX_W-1:0] ci;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = 0;
    ci  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      c = int'(ptr) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      ci = IDX_W'(c);
      if (!any && req[ci]) begin
        any     = 1'b1;
        gnt[ci] = 1'b1;
        idx     = ci;
      end
    end
  end

endmodule

// File: rtl/nasti_lite_uart_arbiter.sv
// Shares one NASTI-Lite UART slave among NUM_REQ requesters, one transaction
// at a time. Define UART_ARB_RR_EN for round-robin, else fixed priority.
module nasti_lite_uart_arbiter
  import nasti_lite_uart_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int UART_ADDR  = UART_DATA_REG
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic                          aw_valid,
  input  logic                          aw_ready,
  output logic [ADDR_WIDTH-1:0]         aw_addr,
  output logic [ID_WIDTH-1:0]           aw_id,
  output logic                          w_valid,
  input  logic                          w_ready,
  output logic [DATA_WIDTH-1:0]         w_data,
  output logic                          w_strb,
  input  logic                          b_valid,
  output logic                          b_ready,
  input  logic [ID_WIDTH-1:0]           b_id,
  output logic                          ar_valid,
  input  logic                          ar_ready,
  output logic [ADDR_WIDTH-1:0]         ar_addr,
  output logic [ID_WIDTH-1:0]           ar_id,
  input  logic                          r_valid,
  output logic                          r_ready,
  input  logic [DATA_WIDTH-1:0]         r_data,
  input  logic [ID_WIDTH-1:0]           r_id
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t                state_q, state_d;
  logic [IW-1:0]         gnt_q, gnt_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;

  logic [NUM_REQ-1:0]    arb_gnt;
  logic [IW-1:0]         arb_idx;
  logic                  arb_any;
  logic [IW-1:0]         ptr;
  logic                  rsp_hs;

  // Responses carry no routing information we trust; the grant register does.
  logic unused_ids;
  assign unused_ids = ^{b_id, r_id};

  assign rsp_hs = (state_q == RSP) && rsp_ready[gnt_q];

`ifdef UART_ARB_RR_EN
  logic [IW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (rsp_hs) ptr_d = (gnt_q == IW'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IW)
  ) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          gnt_d   = arb_idx;
          wdata_d = req_wdata[arb_idx*DATA_WIDTH +: DATA_WIDTH];
          state_d = req_write[arb_idx] ? WR : RD;
        end
      end
      WR: begin
        // AW and W complete independently, possibly in the same cycle.
        if (aw_valid && aw_ready) aw_done_d = 1'b1;
        if (w_valid && w_ready)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WR_RESP;
        end
      end
      WR_RESP: if (b_valid) state_d = RSP;
      RD:      if (ar_ready) state_d = RD_RESP;
      RD_RESP: begin
        if (r_valid) begin
          rdata_d = r_data;
          state_d = RSP;
        end
      end
      RSP:     if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == RSP) rsp_valid[gnt_q] = 1'b1;
  end

  assign req_ready = (state_q == IDLE) ? arb_gnt : '0;
  assign aw_valid  = (state_q == WR) && !aw_done_q;
  assign w_valid   = (state_q == WR) && !w_done_q;
  assign b_ready   = (state_q == WR_RESP);
  assign ar_valid  = (state_q == RD);
  assign r_ready   = (state_q == RD_RESP);
  assign aw_addr   = ADDR_WIDTH'(UART_ADDR);
  assign ar_addr   = ADDR_WIDTH'(UART_ADDR);
  assign aw_id     = ID_WIDTH'(gnt_q);
  assign ar_id     = ID_WIDTH'(gnt_q);
  assign w_data    = wdata_q;
  assign w_strb    = 1'b1;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_nasti_lite_uart_arbiter.sv
// Bench for nasti_lite_uart_arbiter: behavioural UART slave, directed vector
// table, hand sequences for hold/reset/arbitration, and a randomized phase.
module tb_nasti_lite_uart_arbiter;

  localparam int N  = 2;
  localparam int DW = 8;
`ifdef UART_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic [N-1:0]  req_valid, req_write, req_ready, rsp_valid, rsp_ready;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0] rsp_rdata;
  logic          aw_valid, aw_ready, w_valid, w_ready, w_strb;
  logic          b_valid, b_ready, ar_valid, ar_ready, r_valid, r_ready;
  logic [7:0]    aw_addr, ar_addr;
  logic [0:0]    aw_id, ar_id, b_id, r_id;
  logic [DW-1:0] w_data, r_data;

  always #5 clk = ~clk;

  nasti_lite_uart_arbiter dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_write(req_write), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_ready(rsp_ready),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_id(aw_id),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
    .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_id(r_id)
  );

  // UART slave model: acts on the falling edge, ready after a configurable wait
  int aw_lat, w_lat, ar_lat;
  logic [7:0] rx_byte;
  int   aw_wait, w_wait, ar_wait, aw_cyc, w_cyc, ar_cyc, n_b;
  bit   aw_got, w_got, hs_aw, hs_w, hs_ar, hs_b, hs_r;
  logic [7:0] last_wdata, last_aw_addr, last_ar_addr;
  logic last_aw_id, last_ar_id, last_wstrb;

  initial begin
    aw_ready = 0; w_ready = 0; ar_ready = 0; b_valid = 0; r_valid = 0;
    r_data = 0; b_id = 0; r_id = 0;
    aw_wait = 0; w_wait = 0; ar_wait = 0; aw_cyc = 0; w_cyc = 0; ar_cyc = 0; n_b = 0;
    aw_got = 0; w_got = 0; hs_aw = 0; hs_w = 0; hs_ar = 0; hs_b = 0; hs_r = 0;
    last_wdata = 0; last_aw_addr = 0; last_ar_addr = 0;
    last_aw_id = 0; last_ar_id = 0; last_wstrb = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        aw_ready = 0; w_ready = 0; ar_ready = 0; b_valid = 0; r_valid = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0;
        aw_got = 0; w_got = 0; hs_aw = 0; hs_w = 0; hs_ar = 0; hs_b = 0; hs_r = 0;
      end else begin
        if (hs_b) b_valid = 0;
        if (hs_r) r_valid = 0;
        if (hs_aw) aw_got = 1;
        if (hs_w)  w_got  = 1;
        if (aw_got && w_got) begin
          b_valid = 1; b_id = last_aw_id; aw_got = 0; w_got = 0;
        end
        if (hs_ar) begin r_valid = 1; r_data = rx_byte; r_id = last_ar_id; end
        if (aw_valid) aw_cyc++;
        if (w_valid)  w_cyc++;
        if (ar_valid) ar_cyc++;
        aw_ready = aw_valid && (aw_wait >= aw_lat);
        w_ready  = w_valid  && (w_wait  >= w_lat);
        ar_ready = ar_valid && (ar_wait >= ar_lat);
        if (aw_valid && !aw_ready) aw_wait++; else aw_wait = 0;
        if (w_valid  && !w_ready)  w_wait++;  else w_wait  = 0;
        if (ar_valid && !ar_ready) ar_wait++; else ar_wait = 0;
        hs_aw = aw_valid && aw_ready;
        hs_w  = w_valid && w_ready;
        hs_ar = ar_valid && ar_ready;
        hs_b  = b_valid && b_ready;
        hs_r  = r_valid && r_ready;
        if (hs_aw) begin last_aw_id = aw_id[0]; last_aw_addr = aw_addr; end
        if (hs_w)  begin last_wdata = w_data; last_wstrb = w_strb; end
        if (hs_ar) begin last_ar_id = ar_id[0]; last_ar_addr = ar_addr; end
        if (hs_b)  n_b++;
      end
    end
  end

  int n_cmp = 0, n_bad = 0;
  int ref_ptr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Winner: first requesting index found scanning upward from the pointer.
  function automatic int ref_pick(input logic [N-1:0] m, input int p);
    int s = RR ? p : 0;
    for (int k = 0; k < N; k++)
      if (m[(s + k) % N]) return (s + k) % N;
    return -1;
  endfunction

  task automatic txn(input logic [N-1:0] mask, input logic [N-1:0] wrv,
                     input logic [N*DW-1:0] wdv, input int hold, input int poke,
                     output logic [N-1:0] gnt, output int lat,
                     output logic [N-1:0] rv, output logic [DW-1:0] rd);
    int t = 0;
    @(negedge clk);
    req_valid = mask; req_write = wrv; req_wdata = wdv;
    #1;
    while (req_ready == 0 && t < 50) begin @(negedge clk); #1; t++; end
    chk("req_ready_within_bound", t < 50, 1);
    gnt = req_ready;
    @(negedge clk);
    req_valid = '0;
    if (poke >= 0) begin req_valid[poke] = 1'b1; req_write[poke] = 1'b1; end
    #1;
    lat = 1;
    while (rsp_valid == 0 && lat < 300) begin @(negedge clk); #1; lat++; end
    rv = rsp_valid; rd = rsp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk); #1;
      chk($sformatf("hold%0d rsp_valid", h), rsp_valid, rv);
      chk($sformatf("hold%0d rsp_rdata", h), rsp_rdata, rd);
      chk($sformatf("hold%0d req_ready", h), req_ready, 0);
    end
    rsp_ready = rv;
    @(negedge clk);
    rsp_ready = '0; req_valid = '0;
    if (RR && gnt != 0) ref_ptr = ((gnt[1] ? 1 : 0) + 1) % N;
  endtask

  typedef struct {
    int who; bit wr; logic [7:0] wd; logic [7:0] rx;
    int aw_l, w_l, ar_l;
    int e_lat, e_aw, e_w, e_ar;
  } vec_t;

  function automatic vec_t mk(int who, bit wr, logic [7:0] wd, logic [7:0] rx,
                              int aw_l, int w_l, int ar_l,
                              int e_lat, int e_aw, int e_w, int e_ar);
    vec_t v;
    v.who = who; v.wr = wr; v.wd = wd; v.rx = rx;
    v.aw_l = aw_l; v.w_l = w_l; v.ar_l = ar_l;
    v.e_lat = e_lat; v.e_aw = e_aw; v.e_w = e_w; v.e_ar = e_ar;
    return v;
  endfunction

  initial begin
    vec_t vecs[6];
    logic [N-1:0] g, rv, m, wv;
    logic [DW-1:0] rd;
    logic [N*DW-1:0] wdv;
    int lat, a0, w0, r0, b0, e, got, t;

    // latency counts clock edges from the req_ready cycle to the rsp_valid cycle
    vecs[0] = mk(0, 1, 8'h41, 8'h00, 0, 0,  0,  3, 1, 1, 0);
    vecs[1] = mk(1, 0, 8'h00, 8'h5A, 0, 0, 19, 22, 0, 0, 20);
    vecs[2] = mk(0, 1, 8'hC3, 8'h00, 0, 2,  0,  5, 1, 3, 0);
    vecs[3] = mk(1, 1, 8'h7E, 8'h00, 3, 0,  0,  6, 4, 1, 0);
    vecs[4] = mk(0, 0, 8'h00, 8'h99, 0, 0,  0,  3, 0, 0, 1);
    vecs[5] = mk(1, 1, 8'h00, 8'h00, 1, 1,  0,  4, 2, 2, 0);

    rstn = 0; req_valid = 0; req_write = 0; req_wdata = 0; rsp_ready = 0;
    aw_lat = 0; w_lat = 0; ar_lat = 0; rx_byte = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst req_ready", req_ready, 0);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst rsp_rdata", rsp_rdata, 0);
    chk("rst aw_valid", aw_valid, 0);
    chk("rst w_valid", w_valid, 0);
    chk("rst b_ready", b_ready, 0);
    chk("rst ar_valid", ar_valid, 0);
    chk("rst r_ready", r_ready, 0);
    chk("const aw_addr", aw_addr, 0);
    chk("const ar_addr", ar_addr, 0);
    chk("const w_strb", w_strb, 1);
    @(negedge clk);
    rstn = 1;

    for (int i = 0; i < 6; i++) begin
      aw_lat = vecs[i].aw_l; w_lat = vecs[i].w_l; ar_lat = vecs[i].ar_l;
      rx_byte = vecs[i].rx;
      a0 = aw_cyc; w0 = w_cyc; r0 = ar_cyc; b0 = n_b;
      e = ref_pick(N'(1 << vecs[i].who), ref_ptr);
      wdv = '0; wdv[vecs[i].who*DW +: DW] = vecs[i].wd;
      txn(N'(1 << vecs[i].who), N'(vecs[i].wr) << vecs[i].who, wdv, 0, -1, g, lat, rv, rd);
      chk($sformatf("v%0d grant", i), g, 1 << e);
      chk($sformatf("v%0d latency", i), lat, vecs[i].e_lat);
      chk($sformatf("v%0d rsp_valid", i), rv, 1 << vecs[i].who);
      chk($sformatf("v%0d aw_valid_cycles", i), aw_cyc - a0, vecs[i].e_aw);
      chk($sformatf("v%0d w_valid_cycles", i), w_cyc - w0, vecs[i].e_w);
      chk($sformatf("v%0d ar_valid_cycles", i), ar_cyc - r0, vecs[i].e_ar);
      if (vecs[i].wr) begin
        chk($sformatf("v%0d w_data", i), last_wdata, vecs[i].wd);
        chk($sformatf("v%0d aw_id", i), last_aw_id, vecs[i].who);
        chk($sformatf("v%0d w_strb", i), last_wstrb, 1);
        chk($sformatf("v%0d b_count", i), n_b - b0, 1);
      end else begin
        chk($sformatf("v%0d rsp_rdata", i), rd, vecs[i].rx);
        chk($sformatf("v%0d ar_id", i), last_ar_id, vecs[i].who);
        chk($sformatf("v%0d ar_addr", i), last_ar_addr, 0);
      end
    end

    // response held off for 5 cycles while requester 1 is waiting
    aw_lat = 0; w_lat = 0; ar_lat = 0; rx_byte = 8'hA5;
    txn(2'b01, 2'b00, '0, 5, 1, g, lat, rv, rd);
    chk("hold rsp_rdata", rd, 8'hA5);
    chk("hold rsp_valid", rv, 2'b01);

    // reset while a read is stalled on ar_ready
    ar_lat = 1000;
    @(negedge clk);
    req_valid = 2'b01; req_write = 2'b00;
    #1;
    chk("rdrst req_ready", req_ready, 2'b01);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("rdrst ar_valid_before", ar_valid, 1);
    #2 rstn = 0;
    #1;
    chk("rdrst ar_valid_async", ar_valid, 0);
    chk("rdrst r_ready", r_ready, 0);
    repeat (2) @(negedge clk);
    rstn = 1; ar_lat = 0; ref_ptr = 0;
    txn(2'b10, 2'b10, 16'h6600, 0, -1, g, lat, rv, rd);
    chk("post_rst grant", g, 2'b10);
    chk("post_rst latency", lat, 3);
    chk("post_rst w_data", last_wdata, 8'h66);

    // both requesters write back to back
    @(negedge clk);
    req_valid = 2'b11; req_write = 2'b11; req_wdata = 16'hB2A1; rsp_ready = 2'b11;
    got = 0; t = 0;
    while (got < 6 && t < 200) begin
      #1;
      if (req_ready != 0) begin
        e = ref_pick(2'b11, ref_ptr);
        chk($sformatf("cont%0d grant_ref", got), req_ready, 1 << e);
        chk($sformatf("cont%0d grant_seq", got), req_ready, RR ? (1 << (got % 2)) : 1);
        if (RR) ref_ptr = (e + 1) % N;
        got++;
      end
      @(negedge clk);
      t++;
    end
    chk("cont grant_count", got, 6);
    req_valid = '0;
    repeat (6) @(negedge clk);
    rsp_ready = '0;

    for (int i = 0; i < 24; i++) begin
      m   = N'($urandom_range(1, 3));
      wv  = N'($urandom);
      wdv = (N*DW)'($urandom);
      rx_byte = 8'($urandom);
      aw_lat = $urandom_range(0, 3); w_lat = $urandom_range(0, 3);
      ar_lat = $urandom_range(0, 4);
      e = ref_pick(m, ref_ptr);
      txn(m, wv, wdv, $urandom_range(0, 2), -1, g, lat, rv, rd);
      chk($sformatf("rnd%0d grant", i), g, 1 << e);
      chk($sformatf("rnd%0d rsp_valid", i), rv, 1 << e);
      if (wv[e]) begin
        chk($sformatf("rnd%0d w_data", i), last_wdata, wdv[e*DW +: DW]);
        chk($sformatf("rnd%0d aw_id", i), last_aw_id, e);
      end else begin
        chk($sformatf("rnd%0d rsp_rdata", i), rd, rx_byte);
        chk($sformatf("rnd%0d ar_id", i), last_ar_id, e);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
